// File: rtl/alu_unit.sv
// 4-bit registered ALU. Operands are captured when in_valid is high. The result and
// the carry/zero flags are registered and appear on the following edge, with a
// one-cycle out_valid pulse.
module alu_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] opcode,
  output logic [3:0] result,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       out_valid
);

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpNot  = 4'b0100,
    OpMul  = 4'b0101,
    OpDiv  = 4'b0110,
    OpXor  = 4'b0111,
    OpLsl  = 4'b1000,
    OpLsr  = 4'b1001,
    OpAsr  = 4'b1010,
    OpRol  = 4'b1011,
    OpRor  = 4'b1100,
    OpRes0 = 4'b1101,
    OpRes1 = 4'b1110,
    OpPass = 4'b1111
  } op_e;

  logic [4:0] w_sum;
  logic [4:0] w_diff;
  logic [7:0] w_prod;
  logic [3:0] w_div_b;
  logic [3:0] w_quot;
  logic [3:0] w_res;
  logic       w_carry;
  op_e        w_op;

  logic [3:0] r_result;
  logic       r_carry;
  logic       r_zero;
  logic       r_valid;

  // Shared arithmetic terms. The divisor is forced to 1 when B is zero so the
  // quotient is always a defined value; the DIV case then overrides it.
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_prod  = {4'b0000, A} * {4'b0000, B};
    w_div_b = (B == 4'd0) ? 4'd1 : B;
    w_quot  = A / w_div_b;
    w_op    = op_e'(opcode);
  end

  // Decode the opcode into the next result and carry.
  always_comb begin
    w_res   = 4'd0;
    w_carry = 1'b0;
    unique case (w_op)
      OpAdd: begin
        w_res   = w_sum[3:0];
        w_carry = w_sum[4];
      end
      OpSub: begin
        w_res   = w_diff[3:0];
        w_carry = (A < B);
      end
      OpAnd: w_res = A & B;
      OpOr:  w_res = A | B;
      OpNot: w_res = ~A;
      OpMul: begin
        w_res   = w_prod[3:0];
        w_carry = (w_prod[7:4] != 4'd0);
      end
      OpDiv: begin
        w_res   = (B == 4'd0) ? 4'd0 : w_quot;
        w_carry = (B == 4'd0);
      end
      OpXor: w_res = A ^ B;
      OpLsl: begin
        w_res   = {A[2:0], 1'b0};
        w_carry = A[3];
      end
      OpLsr: begin
        w_res   = {1'b0, A[3:1]};
        w_carry = A[0];
      end
      OpAsr: begin
        w_res   = {A[3], A[3:1]};
        w_carry = A[0];
      end
      OpRol: begin
        w_res   = {A[2:0], A[3]};
        w_carry = A[3];
      end
      OpRor: begin
        w_res   = {A[0], A[3:1]};
        w_carry = A[0];
      end
      OpRes0, OpRes1: begin
        w_res   = 4'd0;
        w_carry = 1'b0;
      end
      OpPass: w_res = A;
      default: begin
        w_res   = 4'd0;
        w_carry = 1'b0;
      end
    endcase
  end

  // Output registers: load on a valid strobe and hold otherwise. out_valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 4'd0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_res;
        r_carry  <= w_carry;
        r_zero   <= (w_res == 4'd0);
      end
    end
  end

  assign result     = r_result;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign out_valid  = r_valid;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit. The stimulus pushes hand-computed expectations into
// a queue. The monitor pops one entry and compares it whenever out_valid is high.
module tb_alu_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] opcode;
  logic [3:0] result;
  logic       carry_flag;
  logic       zero_flag;
  logic       out_valid;

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       c;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_unit u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one operation at the falling edge and record its expected response.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] res, input logic c, input logic z);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    e.op = op; e.res = res; e.c = c; e.z = z;
    exp_q.push_back(e);
  endtask

  // Monitor: sample after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("result op%b", e.op), int'(result), int'(e.res));
        check($sformatf("carry op%b", e.op), int'(carry_flag), int'(e.c));
        check($sformatf("zero op%b", e.op), int'(zero_flag), int'(e.z));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 4'd0;
    B        = 4'd0;
    opcode   = 4'd0;
    #3;
    check("reset result", int'(result), 0);
    check("reset carry", int'(carry_flag), 0);
    check("reset zero", int'(zero_flag), 0);
    check("reset out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back directed vectors.
    issue(4'b0000, 4'd7,  4'd8,  4'd15, 1'b0, 1'b0); // ADD
    issue(4'b0000, 4'd15, 4'd1,  4'd0,  1'b1, 1'b1); // ADD wrap
    issue(4'b0001, 4'd5,  4'd5,  4'd0,  1'b0, 1'b1); // SUB
    issue(4'b0001, 4'd3,  4'd5,  4'd14, 1'b1, 1'b0); // SUB borrow
    issue(4'b0010, 4'ha,  4'hc,  4'h8,  1'b0, 1'b0); // AND
    issue(4'b0011, 4'hc,  4'h3,  4'hf,  1'b0, 1'b0); // OR
    issue(4'b0100, 4'hc,  4'h5,  4'h3,  1'b0, 1'b0); // NOT
    issue(4'b0111, 4'hf,  4'h0,  4'hf,  1'b0, 1'b0); // XOR
    issue(4'b0101, 4'd3,  4'd4,  4'd12, 1'b0, 1'b0); // MUL
    issue(4'b0101, 4'd8,  4'd4,  4'd0,  1'b1, 1'b1); // MUL overflow
    issue(4'b0110, 4'd9,  4'd3,  4'd3,  1'b0, 1'b0); // DIV
    issue(4'b0110, 4'd5,  4'd0,  4'd0,  1'b1, 1'b1); // DIV by zero
    issue(4'b1000, 4'b0101, 4'd0, 4'b1010, 1'b0, 1'b0); // LSL
    issue(4'b1001, 4'b1010, 4'd0, 4'b0101, 1'b0, 1'b0); // LSR
    issue(4'b1010, 4'b1010, 4'd0, 4'b1101, 1'b0, 1'b0); // ASR
    issue(4'b1011, 4'b1001, 4'd0, 4'b0011, 1'b1, 1'b0); // ROL
    issue(4'b1100, 4'b1001, 4'd0, 4'b1100, 1'b1, 1'b0); // ROR
    issue(4'b1101, 4'd7,  4'd3,  4'd0,  1'b0, 1'b1); // reserved
    issue(4'b1110, 4'd7,  4'd3,  4'd0,  1'b0, 1'b1); // reserved
    issue(4'b1111, 4'd9,  4'd2,  4'd9,  1'b0, 1'b0); // PASS

    // Idle for 3 cycles with junk inputs: outputs must hold PASS's result.
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 4'b0000;
    A        = 4'd1;
    B        = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("idle out_valid", int'(out_valid), 0);
      check("idle result hold", int'(result), 9);
      check("idle carry hold", int'(carry_flag), 0);
      check("idle zero hold", int'(zero_flag), 0);
    end

    // Reset between edges in the middle of a valid stream.
    issue(4'b0000, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    opcode = 4'b1111;
    A      = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset result", int'(result), 0);
    check("async reset carry", int'(carry_flag), 0);
    check("async reset zero", int'(zero_flag), 0);
    check("async reset out_valid", int'(out_valid), 0);
    @(posedge clk);
    #2;
    check("held reset out_valid", int'(out_valid), 0);
    check("held reset result", int'(result), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    issue(4'b0001, 4'd2, 4'd3, 4'd15, 1'b1, 1'b0); // first post-reset op
    @(negedge clk);
    in_valid = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
